// File: rtl/array_check_pkg.sv
// Shared types and constants for the array_check_arbiter slice.
package array_check_pkg;

    localparam int unsigned IDX_W              = 5;
    localparam int unsigned CLIENTS            = 2;
    localparam int unsigned DEF_GO_CYCLES      = 2;
    localparam int unsigned DEF_TIMEOUT_CYCLES = 64;

    typedef logic [$clog2(CLIENTS)-1:0] client_t;

    typedef enum logic [2:0] {
        IDLE,
        GRANT,
        GO,
        WAIT,
        RESP
    } state_t;

endpackage

// File: rtl/rr_arbiter_2.sv
// Combinational two-way round-robin pick; the caller owns the `last` register.
module rr_arbiter_2
    import array_check_pkg::*;
(
    input  logic    req0,
    input  logic    req1,
    input  client_t last,
    output client_t winner,
    output logic    valid
);

    always_comb begin
        valid  = req0 | req1;
        winner = '0;
        if (req0 && req1) begin
            winner = ~last;
        end else if (req1) begin
            winner = client_t'(1);
        end
    end

endmodule

// File: rtl/array_check_arbiter.sv
// Two-client round-robin front end for a shared arraySortCheck engine.
// Optional WAIT watchdog enabled by defining ARRAY_CHECK_TIMEOUT_EN.
module array_check_arbiter
    import array_check_pkg::*;
#(
    parameter int unsigned GO_CYCLES      = DEF_GO_CYCLES,
    parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             req0,
    input  logic [IDX_W-1:0] array0,
    input  logic [IDX_W-1:0] length0,
    input  logic             req1,
    input  logic [IDX_W-1:0] array1,
    input  logic [IDX_W-1:0] length1,
    output logic             grant0,
    output logic             grant1,
    output logic             resp_valid0,
    output logic             resp_valid1,
    output logic             resp_sorted,
    output logic             resp_error,
    output logic             busy,
    output logic             eng_go,
    output logic [IDX_W-1:0] eng_array,
    output logic [IDX_W-1:0] eng_length,
    input  logic             eng_done,
    input  logic             eng_sorted
);

    localparam int unsigned GO_W = (GO_CYCLES > 1) ? $clog2(GO_CYCLES) : 1;

    if (GO_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("GO_CYCLES and TIMEOUT_CYCLES must be at least 1");
    end

    state_t           state, state_next;
    client_t          last, owner, arb_winner;
    logic             arb_valid;
    logic [IDX_W-1:0] arr_q, len_q;
    logic [GO_W-1:0]  go_cnt;
    logic             armed;
    logic             sorted_q;
    logic             done_hit;
    logic             timeout_hit;

    rr_arbiter_2 u_arb (
        .req0   (req0),
        .req1   (req1),
        .last   (last),
        .winner (arb_winner),
        .valid  (arb_valid)
    );

    // A done only counts once the engine has been seen low in this WAIT,
    // so a done still high from the previous job is ignored.
    assign done_hit = (state == WAIT) && armed && eng_done;

`ifdef ARRAY_CHECK_TIMEOUT_EN
    localparam int unsigned TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [TMO_W-1:0] tmo_cnt;
    logic             error_q;

    assign timeout_hit = (state == WAIT) && !done_hit
                         && (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clock) begin
        if (reset) begin
            tmo_cnt <= '0;
            error_q <= 1'b0;
        end else begin
            if (state == WAIT) begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end else begin
                tmo_cnt <= '0;
            end
            if (state == GRANT) begin
                error_q <= 1'b0;
            end else if (timeout_hit) begin
                error_q <= 1'b1;
            end
        end
    end

    assign resp_error = (state == RESP) && error_q;
`else
    assign timeout_hit = 1'b0;
    assign resp_error  = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (arb_valid) begin
                    state_next = GRANT;
                end
            end
            GRANT: begin
                state_next = (len_q == '0) ? RESP : GO;
            end
            GO: begin
                if (go_cnt == GO_W'(GO_CYCLES - 1)) begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (done_hit || timeout_hit) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            last     <= client_t'(1);
            owner    <= '0;
            arr_q    <= '0;
            len_q    <= '0;
            go_cnt   <= '0;
            armed    <= 1'b0;
            sorted_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (arb_valid) begin
                        owner <= arb_winner;
                        arr_q <= (arb_winner == client_t'(1)) ? array1  : array0;
                        len_q <= (arb_winner == client_t'(1)) ? length1 : length0;
                    end
                end
                GRANT: begin
                    last   <= owner;
                    go_cnt <= '0;
                    if (len_q == '0) begin
                        sorted_q <= 1'b1;
                    end
                end
                GO: begin
                    go_cnt <= go_cnt + 1'b1;
                    armed  <= 1'b0;
                end
                WAIT: begin
                    if (!eng_done) begin
                        armed <= 1'b1;
                    end
                    if (done_hit) begin
                        sorted_q <= eng_sorted;
                    end else if (timeout_hit) begin
                        sorted_q <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign busy        = (state != IDLE);
    assign grant0      = (state == GRANT) && (owner == client_t'(0));
    assign grant1      = (state == GRANT) && (owner == client_t'(1));
    assign resp_valid0 = (state == RESP)  && (owner == client_t'(0));
    assign resp_valid1 = (state == RESP)  && (owner == client_t'(1));
    assign resp_sorted = (state == RESP)  && sorted_q;
    assign eng_go      = (state == GO);
    assign eng_array   = arr_q;
    assign eng_length  = len_q;

endmodule

// File: doc/array_check_arbiter.md
Name: array_check_arbiter

Overview:
- Shares one arraySortCheck engine (circuit plus control pair over the 32-entry register file) between two requesters.
- Accepts (array, length) jobs from client 0 and client 1 and arbitrates between them round-robin.
- Sequences the engine's go/done handshake and returns a one-cycle sorted/error response to the client that was granted.
- Sits between the client logic and the engine.

Parameters:
- GO_CYCLES, 2: number of cycles eng_go is held high per job (minimum 1).
- TIMEOUT_CYCLES, 64: watchdog limit in WAIT. Used only when ARRAY_CHECK_TIMEOUT_EN is defined.

Ports:
- clock in 1: single clock, rising edge.
- reset in 1: synchronous, active-high.
- req0 in 1: client 0 request; held high until resp_valid0.
- array0 in 5: client 0 base register index.
- length0 in 5: client 0 element count.
- req1, array1, length1 in 1/5/5: same signals for client 1.
- grant0 out 1: one-cycle pulse; client 0 operands latched.
- grant1 out 1: one-cycle pulse; client 1 operands latched.
- resp_valid0 out 1: one-cycle response strobe to client 0.
- resp_valid1 out 1: one-cycle response strobe to client 1.
- resp_sorted out 1: result; valid only while a resp_valid is high.
- resp_error out 1: timeout flag; valid only while a resp_valid is high.
- busy out 1: high in every state except IDLE.
- eng_go out 1: go input to the engine control.
- eng_array out 5: latched array, held stable from GRANT through WAIT.
- eng_length out 5: latched length, held stable from GRANT through WAIT.
- eng_done in 1: done output of the engine.
- eng_sorted in 1: sorted output of the engine.

Behaviour:
- Reset: all outputs 0. State IDLE. Round-robin pointer last=1, so client 0 wins the first tie. Latched operands cleared. Reset mid-job aborts with no response; the engine shares the reset.
- States: IDLE, GRANT, GO, WAIT, RESP.
- IDLE:
  - Only req0 high → winner 0. Only req1 high → winner 1.
  - Both high → winner is the client that is not `last`.
  - Neither high → stay in IDLE.
  - On a win: go to GRANT, latch winner id, array and length at that edge.
- GRANT (1 cycle):
  - grantN = 1; set last = winner.
  - Latched length == 0 → go to RESP with sorted=1, error=0. eng_go is never asserted.
  - Otherwise → go to GO.
- GO: eng_go = 1 for exactly GO_CYCLES cycles (counter), then go to WAIT with eng_go = 0.
- WAIT:
  - An `armed` flag clears on entry and sets once eng_done is sampled 0.
  - When armed and eng_done == 1: capture eng_sorted and go to RESP. This rejects a stale done left over from the previous job.
- RESP (1 cycle):
  - resp_validN = 1, with resp_sorted and resp_error driven.
  - Next state IDLE.
- Client rule: req must be low in the cycle after resp_validN. A req that drops before its grant is simply not served.
- Latency:
  - Zero-length job: req seen at edge N → grant in cycle N+1 → response in cycle N+2.
  - Other jobs: grant in cycle N+1; eng_go high cycles N+2 … N+1+GO_CYCLES; response one cycle after the armed eng_done.
- Requests arriving while busy wait in place; they are not queued.
- The losing client is guaranteed service on the next arbitration after the current job.

Optional Feature:
- Macro ARRAY_CHECK_TIMEOUT_EN.
- Defined:
  - A WAIT-state counter starts at 0 on entry.
  - If it reaches TIMEOUT_CYCLES without an armed done → go to RESP with resp_error=1, resp_sorted=0.
  - The engine is not reset; its next go restarts it.
- Undefined: no counter is built, resp_error is tied to 0, and WAIT can last indefinitely.

Decomposition:
- Package array_check_pkg:
  - State enum (IDLE, GRANT, GO, WAIT, RESP).
  - IDX_W=5, CLIENTS=2.
  - Default GO_CYCLES/TIMEOUT_CYCLES constants.
- Sub-module rr_arbiter_2: combinational two-way round-robin pick from (req0, req1, last), output winner plus valid. The FSM owns the `last` register.

Test Plan:
- Register file r[i]=i; req0 with array=11, length=5 → grant0 in cycle 1, eng_array=11, then resp_valid0 with resp_sorted=1 and resp_error=0.
- r[2..6]={1,2,3,2,5}; req1 with array=2, length=5 → resp_valid1 with resp_sorted=0.
- req0 and req1 both high in the same cycle after reset (array0=11/length0=5, array1=7/length1=3) → client 0 is served first, then grant1 follows within 1 cycle of IDLE; a second simultaneous pair → client 1 is served first.
- req0 with length=0 → grant0 at +1, resp_valid0 with resp_sorted=1 at +2, eng_go stays 0 throughout.
- eng_done stubbed high at job start, then 0, then 1 → response only after the 0→1 transition; a stale done never produces a response.
- Reset asserted during WAIT → next cycle all outputs 0 and state IDLE. Under ARRAY_CHECK_TIMEOUT_EN, eng_done held 0 → resp_error=1 exactly 64 cycles after WAIT entry.
